// File: rtl/mfc_frame_reader.sv
// mfc_frame_reader: walks the speech-sample BRAM as overlapping frames
// (FRAME_LEN samples, stride HOP) and streams each sample over valid/ready.
// Optional pre-emphasis y = x - alpha*prev is enabled by defining FRAME_PREEMPH_EN.
module mfc_frame_reader #(
    parameter int DWIDTH    = 30,
    parameter int AWIDTH    = 9,
    parameter int WORDS     = 400,
    parameter int FRAME_LEN = 160,
    parameter int HOP       = 80,
    parameter int ALPHA_Q15 = 31785
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] bram_addr,
    input  logic [DWIDTH-1:0] bram_rdata,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [7:0]        frame_idx
);

    localparam int                HOP_SAFE = (HOP > 0) ? HOP : 1;
    localparam int                NFRAMES  = (WORDS - FRAME_LEN) / HOP_SAFE + 1;
    localparam logic [AWIDTH-1:0] LAST_N   = AWIDTH'(FRAME_LEN - 1);
    localparam logic [7:0]        LAST_F   = 8'(NFRAMES - 1);
    localparam logic [AWIDTH-1:0] HOP_A    = AWIDTH'(HOP_SAFE);

    if (FRAME_LEN > WORDS || FRAME_LEN <= 0 || HOP <= 0 || WORDS > (1 << AWIDTH) ||
        ALPHA_Q15 < 0 || ALPHA_Q15 > 65535) begin : g_bad_cfg
        $error("mfc_frame_reader: invalid frame geometry or coefficient");
    end

    // PRIME presents base-1; PADDR presents base while the primed word arrives.
    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_PADDR, S_ADDR, S_CAPT, S_OUT, S_NEXT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] base_q, base_d;
    logic [AWIDTH-1:0] n_q, n_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [7:0]        fidx_q, fidx_d;
    logic [DWIDTH-1:0] data_q, data_d;
`ifdef FRAME_PREEMPH_EN
    logic [DWIDTH-1:0] prev_q, prev_d;
    logic [DWIDTH-1:0] raw_q, raw_d;

    function automatic logic [DWIDTH-1:0] preemph(input logic [DWIDTH-1:0] x,
                                                   input logic [DWIDTH-1:0] p);
        logic signed [2*DWIDTH:0] prod;
        logic signed [DWIDTH:0]   diff;
        prod = $signed((2*DWIDTH+1)'(ALPHA_Q15)) *
               $signed({{(DWIDTH+1){p[DWIDTH-1]}}, p});
        prod = prod >>> 15;
        diff = $signed({x[DWIDTH-1], x}) - $signed(prod[DWIDTH:0]);
        if (diff[DWIDTH] != diff[DWIDTH-1])
            return diff[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
        return diff[DWIDTH-1:0];
    endfunction
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            n_q     <= '0;
            addr_q  <= '0;
            fidx_q  <= '0;
            data_q  <= '0;
`ifdef FRAME_PREEMPH_EN
            prev_q  <= '0;
            raw_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            fidx_q  <= fidx_d;
            data_q  <= data_d;
`ifdef FRAME_PREEMPH_EN
            prev_q  <= prev_d;
            raw_q   <= raw_d;
`endif
        end
    end

    // Next-state, address sequencing and sample capture
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        n_d     = n_q;
        addr_d  = addr_q;
        fidx_d  = fidx_q;
        data_d  = data_q;
`ifdef FRAME_PREEMPH_EN
        prev_d  = prev_q;
        raw_d   = raw_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = '0;
                    n_d     = '0;
                    fidx_d  = '0;
                    addr_d  = '0;
`ifdef FRAME_PREEMPH_EN
                    prev_d  = '0;
`endif
                    state_d = S_ADDR;
                end
            end
            S_PRIME: begin
                addr_d  = base_q;
                state_d = S_PADDR;
            end
            S_PADDR: begin
`ifdef FRAME_PREEMPH_EN
                prev_d  = bram_rdata;
`endif
                state_d = S_CAPT;
            end
            S_ADDR: state_d = S_CAPT;
            S_CAPT: begin
`ifdef FRAME_PREEMPH_EN
                raw_d  = bram_rdata;
                data_d = preemph(bram_rdata, prev_q);
`else
                data_d = bram_rdata;
`endif
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
`ifdef FRAME_PREEMPH_EN
                    prev_d = raw_q;
`endif
                    if (n_q == LAST_N) begin
                        state_d = S_NEXT;
                    end else begin
                        n_d     = n_q + 1'b1;
                        addr_d  = base_q + n_q + 1'b1;
                        state_d = S_ADDR;
                    end
                end
            end
            S_NEXT: begin
                fidx_d = fidx_q + 1'b1;
                n_d    = '0;
                if (fidx_q == LAST_F) begin
                    state_d = S_DONE;
                end else begin
                    base_d = base_q + HOP_A;
`ifdef FRAME_PREEMPH_EN
                    addr_d  = base_q + HOP_A - 1'b1;
                    state_d = S_PRIME;
`else
                    addr_d  = base_q + HOP_A;
                    state_d = S_ADDR;
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign out_valid = (state_q == S_OUT);
    assign out_last  = out_valid && (n_q == LAST_N);
    assign out_data  = data_q;
    assign bram_addr = addr_q;
    assign frame_idx = fidx_q;

endmodule

// File: tb/tb_mfc_frame_reader.sv
// tb_mfc_frame_reader: scoreboard bench. The stimulus process computes every
// frame sample from the BRAM contents and queues it; a negedge monitor pops and
// compares each accepted beat. Honours FRAME_PREEMPH_EN like the design.
module tb_mfc_frame_reader;
    localparam int    DW    = 30;
    localparam int    AW    = 9;
    localparam int    WORDS = 400;
    localparam int    FL    = 160;
    localparam int    HOP   = 80;
    localparam int    NF    = (WORDS - FL) / HOP + 1;
    localparam int    ALPHA = 31785;
    localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DW - 1));

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_rdata = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic [7:0]    frame_idx;

    mfc_frame_reader #(
        .DWIDTH(DW), .AWIDTH(AW), .WORDS(WORDS), .FRAME_LEN(FL), .HOP(HOP), .ALPHA_Q15(ALPHA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .bram_addr(bram_addr), .bram_rdata(bram_rdata), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_idx(frame_idx)
    );

    typedef struct {
        longint d;
        bit     last;
        int     fidx;
    } exp_t;

    exp_t   exp_q[$];
    int     mem[WORDS];
    longint cap[8192];
    int     total = 0;
    int     bad = 0;
    int     beats = 0;
    int     lasts = 0;
    int     dones = 0;
    int     max_addr = 0;
    bit     rand_ready = 1'b0;

    initial forever #5 clk = ~clk;

    // BRAM: one-cycle read latency
    initial forever begin
        @(posedge clk);
        if (int'(bram_addr) < WORDS) bram_rdata <= DW'(mem[bram_addr]);
        else bram_rdata <= '0;
    end

    // Consumer backpressure
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: sample k of frame f, pre-emphasised against the preceding BRAM word
    function automatic longint model(input int f, input int k);
        int     a;
        longint x, y, p;
        a = f * HOP + k;
        x = longint'(mem[a]);
        y = x;
        p = 0;
`ifdef FRAME_PREEMPH_EN
        if (a > 0) p = longint'(mem[a - 1]);
        y = x - ((longint'(ALPHA) * p) >>> 15);
        if (y > MAXV) y = MAXV;
        if (y < MINV) y = MINV;
`endif
        return y + 0 * p;
    endfunction

    // Monitor: pops the scoreboard on every accepted beat
    initial begin
        bit            stalled;
        logic [DW-1:0] held;
        exp_t          e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                stalled = 1'b0;
            end else begin
                if (int'(bram_addr) > max_addr) max_addr = int'(bram_addr);
                if (stalled && out_valid)
                    chk("stall_data", longint'($signed(out_data)), longint'($signed(held)));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", longint'($signed(out_data)), e.d);
                        chk("beat_last", longint'(out_last), longint'(e.last));
                        chk("beat_fidx", longint'(frame_idx), longint'(e.fidx));
                    end
                    if (beats < 8192) cap[beats] = longint'($signed(out_data));
                    beats++;
                    if (out_last) lasts++;
                end
                stalled = out_valid && !out_ready;
                held    = out_data;
                if (done) dones++;
            end
        end
    end

    task automatic push_run();
        exp_t e;
        for (int f = 0; f < NF; f++)
            for (int k = 0; k < FL; k++) begin
                e.d    = model(f, k);
                e.last = (k == FL - 1);
                e.fidx = f;
                exp_q.push_back(e);
            end
    endtask

    // Full run: queue expectations, pulse start, check latency, wait for done
    task automatic run(input bit rnd, output int first_beat);
        int  b0, l0, d0;
        bit  seen;
        @(posedge clk);
        #1;
        rand_ready = rnd;
        push_run();
        b0 = beats; l0 = lasts; d0 = dones;
        first_beat = b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", longint'(busy), 1);
        @(posedge clk);
        #1;
        chk("valid_lat1", longint'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("valid_lat2", longint'(out_valid), 1);
        seen = 1'b0;
        for (int c = 0; c < 20000 && !seen; c++) begin
            @(negedge clk);
            start = (c == 50);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", longint'(seen), 1);
        repeat (3) @(negedge clk);
        chk("beat_count", longint'(beats - b0), NF * FL);
        chk("last_count", longint'(lasts - l0), NF);
        chk("done_count", longint'(dones - d0), 1);
        chk("queue_empty", longint'(exp_q.size()), 0);
        chk("idle_busy", longint'(busy), 0);
    endtask

    initial begin
        int  s, b0, d0, v;
        bit  hit;
        for (int i = 0; i < WORDS; i++) mem[i] = i * 1000;
        repeat (3) @(negedge clk);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_last", longint'(out_last), 0);
        chk("rst_data", longint'(out_data), 0);
        chk("rst_addr", longint'(bram_addr), 0);
        chk("rst_fidx", longint'(frame_idx), 0);
        rst_n = 1'b1;

        // Ramp data, no backpressure
        run(1'b0, s);
        chk("f0_b0", cap[s], 0);
        chk("f0_b1", cap[s + 1], 1000);
`ifdef FRAME_PREEMPH_EN
        chk("f0_b2", cap[s + 2], 1030);
        chk("f1_b0", cap[s + FL], 3370);
`else
        chk("f0_b2", cap[s + 2], 2000);
        chk("f1_b0", cap[s + FL], 80000);
        chk("f3_b159", cap[s + 4 * FL - 1], (3 * 80 + 159) * 1000);
`endif

        // Same data under random backpressure
        run(1'b1, s);
        chk("bp_f0_b2", cap[s + 2], model(0, 2));

        // Saturation corner
        mem[10] = -536870912;
        mem[11] = 536870911;
        run(1'b1, s);
        chk("sat_b11", cap[s + 11], 536870911);

        // Random signed samples with extremes
        for (int i = 0; i < WORDS; i++) begin
            v = $signed($urandom) >>> 2;
            case ($urandom_range(0, 9))
                0: v = -536870912;
                1: v = 536870911;
                default: ;
            endcase
            mem[i] = v;
        end
        run(1'b1, s);

        // Reset in frame 2, beat 50, then a fresh run
        for (int i = 0; i < WORDS; i++) mem[i] = i * 1000;
        @(posedge clk);
        #1;
        rand_ready = 1'b0;
        push_run();
        b0 = beats;
        d0 = dones;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 20000 && !hit; c++) begin
            @(negedge clk);
            if (beats - b0 >= 2 * FL + 50) hit = 1'b1;
        end
        chk("abort_point", longint'(hit), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", longint'(out_valid), 0);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_fidx", longint'(frame_idx), 0);
        repeat (3) @(negedge clk);
        chk("abort_valid_hold", longint'(out_valid), 0);
        chk("abort_no_done", longint'(dones - d0), 0);
        rst_n = 1'b1;
        run(1'b0, s);
        chk("restart_b0", cap[s], 0);
        chk("restart_b1", cap[s + 1], 1000);

        chk("max_addr", longint'(max_addr), WORDS - 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
